// File: rtl/cs_y_collector.sv
// cs_y_collector: downstream collector for the CS core Y stream.
// Throws away the first WARMUP enabled samples after reset or flush,
// while the CS window is still filling. After that, every enabled sample
// is pushed into a DEPTH-entry FIFO. The FIFO is read out through a
// valid/ready handshake. Samples that arrive while the FIFO is full are
// dropped, and each drop is recorded in a sticky overflow flag and a
// saturating counter.
//
// Ports:
//   clk_i        system clock, posedge
//   rst_ni       asynchronous active-low reset
//   en_i         sample enable, one Y per enabled cycle
//   flush_i      synchronous FIFO clear plus warm-up restart; wins over push/pop
//   y_i          Y sample from CS
//   out_data_o   FIFO head, 0 while empty
//   out_valid_o  FIFO non-empty
//   out_ready_i  downstream accept
//   level_o      FIFO occupancy, 0..DEPTH
//   overflow_o   sticky, set on the first dropped sample
//   drop_cnt_o   dropped sample count, saturates at 255
//   capturing_o  high once warm-up is complete
module cs_y_collector #(
    parameter int unsigned WARMUP = 9,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = 3,
    parameter int unsigned DW     = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          flush_i,
    input  logic [DW-1:0] y_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt_o,
    output logic          capturing_o
);

    localparam int unsigned WCW = $clog2(WARMUP + 1);

    localparam logic [AW:0]    LvlFull  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    LvlOne   = (AW + 1)'(1);
    localparam logic [AW-1:0]  PtrOne   = AW'(1);
    localparam logic [WCW-1:0] WarmOne  = WCW'(1);
    localparam logic [WCW-1:0] WarmLast = WCW'(WARMUP - 1);

    typedef enum logic [0:0] {StWarm, StRun} state_e;

    state_e          state_q, state_d;
    logic [WCW-1:0]  warm_q, warm_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_q, drop_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic pop, push_req, full, push, drop;

    always_comb begin
        pop      = (level_q != '0) && out_ready_i;
        push_req = (state_q == StRun) && en_i;
        full     = (level_q == LvlFull);
        // A full FIFO still accepts a push when a pop frees the head slot
        // in the same cycle.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (flush_i) begin
            // Overflow history is kept; only reset clears it.
            state_d  = StWarm;
            warm_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            unique case (state_q)
                StWarm: begin
                    if (en_i) begin
                        if (warm_q == WarmLast) begin
                            state_d = StRun;
                            warm_d  = '0;
                        end else begin
                            warm_d = warm_q + WarmOne;
                        end
                    end
                end
                StRun: begin
                end
            endcase

            if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
            if (push) wr_ptr_d = wr_ptr_q + PtrOne;

            if (push && !pop)      level_d = level_q + LvlOne;
            else if (pop && !push) level_d = level_q - LvlOne;

            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StWarm;
            warm_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // The storage array has no reset. out_data_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= y_i;
    end

    always_comb begin
        out_valid_o = (level_q != '0);
        out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
        level_o     = level_q;
        overflow_o  = overflow_q;
        drop_cnt_o  = drop_q;
        capturing_o = (state_q == StRun);
    end

endmodule

// File: tb/tb_cs_y_collector.sv
// Self-checking bench for cs_y_collector.
// The stimulus process drives the inputs and updates a behavioural model at
// every posedge. The model counts samples seen since reset or flush, and it
// appends every accepted Y to a scoreboard queue. A separate monitor runs on
// each negedge. It compares the DUT outputs with the model and pops the
// scoreboard on every handshake.
module tb_cs_y_collector;

    localparam int WARMUP = 9;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int DW     = 10;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic [DW-1:0] y;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          capturing;

    cs_y_collector #(
        .WARMUP(WARMUP),
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .flush_i    (flush),
        .y_i        (y),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .level_o    (level),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt),
        .capturing_o(capturing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int unsigned   seen;      // enabled samples since reset/flush
    int unsigned   mlevel;
    bit            movf;
    int unsigned   mdrops;
    logic [DW-1:0] sb_q[$];   // expected FIFO contents, head first

    int n_assert;
    int n_fail;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_all();
        sb_q.delete();
        mlevel = 0;
        seen   = 0;
        movf   = 1'b0;
        mdrops = 0;
    endtask

    // Model of one clock edge, evaluated with the inputs that were applied.
    task automatic model_step(input bit e, input logic [DW-1:0] yv, input bit rdy, input bit fl);
        bit pop;
        bit cap;
        if (fl) begin
            sb_q.delete();
            mlevel = 0;
            seen   = 0;
        end else begin
            pop = (mlevel > 0) && rdy;
            cap = e && (seen >= WARMUP);
            if (e && seen < WARMUP) seen++;
            if (cap) begin
                if (mlevel < DEPTH || pop) begin
                    sb_q.push_back(yv);
                    mlevel++;
                end else begin
                    movf = 1'b1;
                    if (mdrops < 255) mdrops++;
                end
            end
            if (pop) mlevel--;
        end
    endtask

    // Apply the inputs for one cycle, then update the model at the posedge.
    task automatic drive(input bit e, input logic [DW-1:0] yv, input bit rdy, input bit fl);
        en        = e;
        y         = yv;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        model_step(e, yv, rdy, fl);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("level", level, mlevel);
                check("out_valid", out_valid, (mlevel != 0));
                check("overflow", overflow, movf);
                check("drop_cnt", drop_cnt, mdrops);
                check("capturing", capturing, (seen >= WARMUP));
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        check("head_present", 0, 1);
                    end else begin
                        check("out_data", out_data, sb_q[0]);
                        if (out_ready) void'(sb_q.pop_front());
                    end
                end else begin
                    check("out_data_empty", out_data, 0);
                end
            end
        end
    end

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        model_clear_all();
        rst_n     = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        y         = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_cap", capturing, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Warm-up: 0x001..0x009 discarded, 0x00A..0x00C delivered.
        for (int i = 1; i <= 12; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Overfill while stalled: 0x108 and 0x109 are dropped.
        for (int i = 0; i < 10; i++) drive(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        check("ovf_after_fill", overflow, 1);
        check("drop_after_fill", drop_cnt, 2);

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'h200 + i), 1'b1, 1'b0);
        check("level_full_pp", level, DEPTH);

        // Drain down to 3 entries, stall, then drain completely.
        while (mlevel > 3) drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        check("drained_level", level, 0);

        // Flush with 5 entries stored, then a second warm-up.
        for (int i = 0; i < 5; i++) drive(1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
        drive(1'b1, DW'(32'h3FF), 1'b1, 1'b1);
        check("flush_level", level, 0);
        check("flush_cap", capturing, 0);
        check("flush_ovf", overflow, 1);
        for (int i = 0; i < 13; i++) drive(1'b1, DW'(32'h040 + i), 1'b0, 1'b0);

        // Asynchronous reset mid-stream with 4 entries stored.
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_level", level, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_ovf", overflow, 0);
        model_clear_all();
        en        = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 3) != 0, DW'($urandom_range(0, 1023)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
